// File: rtl/ex_ctrl.sv
// EX-stage sequencer: takes one decoded op from ID, drives ALU/TF/DM controls, owns O/S/C/Z, hands one result to WB.
// Latency: 2 cycles for non-memory ops, 2 + DM_LAT for loads/stores (handshake to WB result, wb_ready held high).
// Backpressure: id_ready low outside IDLE and WB+wb_ready; WB fields hold while wb_valid && !wb_ready. EX_CTRL_STALL_CNT_EN adds stall_cnt.
module ex_ctrl #(
    parameter int DM_LAT = 2,
    parameter int RD_W   = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_OP_ALU,
    input  logic [2:0]      id_OP_TF,
    input  logic [2:0]      id_cond,
    input  logic            id_S_MXSE,
    input  logic            id_W_DM,
    input  logic            id_R_DM,
    input  logic            id_W_RF,
    input  logic            id_W_FLAGS,
    input  logic [RD_W-1:0] id_rd,
    input  logic            alu_O,
    input  logic            alu_S,
    input  logic            alu_C,
    input  logic            alu_Z,
    input  logic            tf_out,
    output logic [4:0]      uc_OP_ALU,
    output logic [2:0]      uc_OP_TF,
    output logic [2:0]      tf_cond,
    output logic            uc_S_MXSE,
    output logic            uc_W_DM,
    output logic            rf_O,
    output logic            rf_S,
    output logic            rf_C,
    output logic            rf_Z,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_W_RF,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_sel,
    output logic            br_taken
`ifdef EX_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    localparam logic [3:0] MEM_LOAD = 4'(DM_LAT - 1);

    state_t     state;
    logic [3:0] mem_cnt;
    logic       op_w_dm;
    logic       op_r_dm;
    logic       op_w_flags;
    logic       accept;

    // WB releases the slot in the same cycle it retires, so a waiting op enters EXEC with no bubble.
    assign id_ready = (state == IDLE) || ((state == WB) && wb_ready);
    assign accept   = id_valid && id_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            mem_cnt    <= 4'd0;
            op_w_dm    <= 1'b0;
            op_r_dm    <= 1'b0;
            op_w_flags <= 1'b0;
            uc_OP_ALU  <= 5'd0;
            uc_OP_TF   <= 3'd0;
            tf_cond    <= 3'd0;
            uc_S_MXSE  <= 1'b0;
            uc_W_DM    <= 1'b0;
            rf_O       <= 1'b0;
            rf_S       <= 1'b0;
            rf_C       <= 1'b0;
            rf_Z       <= 1'b0;
            wb_valid   <= 1'b0;
            wb_W_RF    <= 1'b0;
            wb_rd      <= '0;
            wb_sel     <= 1'b0;
            br_taken   <= 1'b0;
        end else begin
            if (accept) begin
                uc_OP_ALU  <= id_OP_ALU;
                uc_OP_TF   <= id_OP_TF;
                tf_cond    <= id_cond;
                uc_S_MXSE  <= id_S_MXSE;
                op_w_dm    <= id_W_DM;
                op_r_dm    <= id_R_DM;
                op_w_flags <= id_W_FLAGS;
                wb_W_RF    <= id_W_RF;
                wb_rd      <= id_rd;
                // A store wins over a simultaneous load, so only a pure load returns dm_Q.
                wb_sel     <= id_R_DM && !id_W_DM;
            end

            case (state)
                IDLE: begin
                    if (id_valid) state <= EXEC;
                end
                EXEC: begin
                    if (op_w_flags) begin
                        rf_O <= alu_O;
                        rf_S <= alu_S;
                        rf_C <= alu_C;
                        rf_Z <= alu_Z;
                    end
                    br_taken <= tf_out;
                    if (op_w_dm || op_r_dm) begin
                        state   <= MEM;
                        mem_cnt <= MEM_LOAD;
                        uc_W_DM <= op_w_dm;
                    end else begin
                        state    <= WB;
                        wb_valid <= 1'b1;
                    end
                end
                MEM: begin
                    uc_W_DM <= 1'b0;
                    if (mem_cnt == 4'd0) begin
                        state    <= WB;
                        wb_valid <= 1'b1;
                    end else begin
                        mem_cnt <= mem_cnt - 4'd1;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= id_valid ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EX_CTRL_STALL_CNT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt <= 16'd0;
        end else if (id_valid && !id_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
